// File: rtl/wb_trace_emitter_pkg.sv
// Shared types for the writeback trace path: the captured payload and its sizing.
package wb_trace_emitter_pkg;

   localparam int unsigned SEQ_W_DEF = 16;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] alu;
      logic [31:0] wb;
      logic [4:0]  wa;
      logic        regwrite;
   } trace_payload_t;

   localparam int unsigned PAYLOAD_W = $bits(trace_payload_t);

endpackage

// File: rtl/wb_trace_emitter_fifo.sv
// Generic fall-through FIFO with separate occupancy counter and synchronous clear.
module wb_trace_emitter_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   level_o
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned LevelW = PtrW + 1;

   logic [Width-1:0]  mem_q [Depth];
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [LevelW-1:0] level_q, level_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (push_i) wptr_d = wptr_q + PtrW'(1);
         if (pop_i)  rptr_d = rptr_q + PtrW'(1);
         unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever empty.
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
   end

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LevelW'(Depth));
   assign level_o = level_q;
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/wb_trace_emitter.sv
// Writeback trace producer: filters retiring events, tags them with a sequence
// number, buffers them and tracks events lost to back-pressure.
module wb_trace_emitter
   import wb_trace_emitter_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned FILTER_RW = 0,
   parameter int unsigned SEQ_W     = SEQ_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_valid_i,
   input  logic [31:0]              wb_inst_i,
   input  logic [31:0]              wb_alu_result_i,
   input  logic [31:0]              wb_data_i,
   input  logic [4:0]               wb_wa_i,
   input  logic                     wb_regwrite_i,
   input  logic                     trace_clr_i,
   output logic                     trace_valid_o,
   input  logic                     trace_ready_i,
   output logic [31:0]              trace_inst_o,
   output logic [31:0]              trace_alu_o,
   output logic [31:0]              trace_wb_o,
   output logic [4:0]               trace_wa_o,
   output logic                     trace_regwrite_o,
   output logic [SEQ_W-1:0]         trace_seq_o,
   output logic                     trace_overflow_o,
   output logic [SEQ_W-1:0]         trace_drops_o,
   output logic [$clog2(DEPTH):0]   trace_level_o
);

   localparam int unsigned RecW = PAYLOAD_W + SEQ_W;

   logic             cap, pop, push, drop, full, empty;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [SEQ_W-1:0] drops_q, drops_d;
   logic             overflow_q, overflow_d;
   trace_payload_t   wr_pl, rd_pl;
   logic [RecW-1:0]  wr_rec, rd_rec;
   logic [SEQ_W-1:0] rd_seq;

   assign cap  = wb_valid_i & ((FILTER_RW != 0) ? wb_regwrite_i : 1'b1);
   assign pop  = trace_valid_o & trace_ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push = cap & (!full | pop);
   assign drop = cap & full & !pop;

   always_comb begin
      seq_d      = seq_q;
      drops_d    = drops_q;
      overflow_d = overflow_q;
      if (trace_clr_i) begin
         seq_d      = '0;
         drops_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (cap) seq_d = seq_q + SEQ_W'(1);
         if (drop) begin
            overflow_d = 1'b1;
            if (drops_q != '1) drops_d = drops_q + SEQ_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q      <= '0;
         drops_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         seq_q      <= seq_d;
         drops_q    <= drops_d;
         overflow_q <= overflow_d;
      end
   end

   assign wr_pl = '{inst: wb_inst_i, alu: wb_alu_result_i, wb: wb_data_i,
                    wa: wb_wa_i, regwrite: wb_regwrite_i};
   assign wr_rec = {wr_pl, seq_q};

   wb_trace_emitter_fifo #(
      .Width (RecW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (trace_clr_i),
      .push_i  (push),
      .wdata_i (wr_rec),
      .pop_i   (pop),
      .rdata_o (rd_rec),
      .full_o  (full),
      .empty_o (empty),
      .level_o (trace_level_o)
   );

   assign {rd_pl, rd_seq}  = rd_rec;
   assign trace_valid_o    = !empty;
   assign trace_inst_o     = rd_pl.inst;
   assign trace_alu_o      = rd_pl.alu;
   assign trace_wb_o       = rd_pl.wb;
   assign trace_wa_o       = rd_pl.wa;
   assign trace_regwrite_o = rd_pl.regwrite;
   assign trace_seq_o      = rd_seq;
   assign trace_overflow_o = overflow_q;
   assign trace_drops_o    = drops_q;

endmodule
